led_pwm: RTL and testbench
==========================

LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter PRESCALE, default 16, clk cycles per PWM tick; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sel  input  1  register select; reads and writes ignored when low.
REQ-005 rstrb  input  1  read strobe; no side effects.
REQ-006 wstrb  input  1  write strobe; a write occurs when sel && wstrb.
REQ-007 addr  input  1  register index: 0 = DUTY, 1 = CTRL.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data; combinational; 32'b0 when sel low.
REQ-010 led_in  input  4  on/off pattern from the upstream LED register.
REQ-011 LED  output  4  registered LED pin drive.

Function
REQ-012 DUTY register: 4 x 8-bit duty values; channel i = wdata[8i+7:8i]; full 32-bit write only.
REQ-013 CTRL register: bits[3:0] per-channel blink enable, bits[15:8] blink half-period in PWM frames; other bits write-ignored, read 0.
REQ-014 Read: sel && addr==0 returns the DUTY write register; sel && addr==1 returns {16'b0, half_period, 4'b0, blink_en}.
REQ-015 Prescaler: counts 0..PRESCALE-1, wraps to 0; tick asserted for the one cycle in which the count equals PRESCALE-1.
REQ-016 PWM counter: 8-bit; increments on tick; wraps 255 -> 0; frame boundary is the tick that wraps it to 0.
REQ-017 Shadow duty: DUTY writes land in the write register immediately; the active duty copy loads from it only at a frame boundary, so no mid-frame glitches.
REQ-018 Write during the boundary cycle: the active copy loads the pre-write value; the new value takes effect at the following boundary.
REQ-019 Blink frame counter: 8-bit; increments at each frame boundary; when it equals half_period-1, it clears to 0 and blink_phase toggles.
REQ-020 half_period == 0: frame counter held at 0 and blink_phase held at 1.
REQ-021 A CTRL write clears the frame counter and sets blink_phase to 1 in the same cycle.
REQ-022 Per-channel raw on condition: led_in[i] && (active_duty[i]==8'hFF || pwm_cnt < active_duty[i]) && (!blink_en[i] || blink_phase).
REQ-023 Duty boundaries: 0 gives always off; 255 gives always on (no 1/256 gap); n in 1..254 gives n/256 on-time per frame.
REQ-024 LED[i] is the raw on condition registered, so it lags led_in, counter and register changes by 1 clk.
REQ-025 Simultaneous write and read of the same register: rdata shows the old value in that cycle and the new value from the next cycle.

Reset
REQ-026 On reset, the following values apply:
- prescaler, pwm_cnt and frame counter = 0;
- blink_phase = 1;
- DUTY write and active registers = 32'hFFFFFFFF, giving steady full brightness so led_in passes through;
- CTRL = 0;
- LED = 4'b0000 on the cycle after reset is sampled.
REQ-027 Reset asserted mid-frame or mid-blink abandons all counts; the first tick after release occurs PRESCALE cycles later.
REQ-028 Reset has priority over a simultaneous bus write; the write is discarded.

Verification
REQ-029 Pass-through: reset, then led_in=4'b1010 with no writes -> LED=4'b1010 one cycle later, constant over 3 frames.
REQ-030 Dimming, PRESCALE=1:
- Stimulus: write DUTY=32'h00_40_80_FF, led_in=4'hF.
- After the next boundary, per 256-cycle frame, LED on-counts are ch0=256, ch1=128, ch2=64, ch3=0.
REQ-031 Shadow timing: write DUTY mid-frame -> duty of the current frame is unchanged; the new duty applies from the first cycle after the boundary (+1 registered cycle).
REQ-032 Blink, PRESCALE=1:
- Stimulus: CTRL = half_period 2, blink_en=4'b0001; DUTY all FF; led_in=4'hF.
- LED[0] alternates 512 cycles on / 512 off; LED[3:1] steady on.
REQ-033 Reset mid-operation: assert reset during blink off-phase at pwm_cnt=100 -> next cycle LED=0, rdata at addr 1 = 0, and pass-through resumes after release.
REQ-034 Bus isolation: wstrb with sel=0 -> registers unchanged; sel=0 -> rdata=0 regardless of addr or rstrb.

Source files
------------

// File: rtl/led_pwm.sv
// led_pwm: 4-channel LED dimmer with shadowed duty registers and per-channel blink.
module led_pwm #(
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        rstrb,
    input  logic        wstrb,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [3:0]  led_in,
    output logic [3:0]  LED
);
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [31:0] duty_wr_q, duty_wr_d;
    logic [31:0] duty_act_q, duty_act_d;
    logic [3:0]  blink_en_q, blink_en_d;
    logic [7:0]  half_q, half_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  led_q, led_d;
    logic        tick, frame, wr_duty, wr_ctrl;
    logic        rstrb_unused;

    // Reads have no side effects, so the strobe carries no information here.
    assign rstrb_unused = rstrb;
    assign LED = led_q;

    always_comb begin
        tick        = presc_q == 16'(PRESCALE - 1);
        frame       = tick && pwm_cnt_q == 8'hFF;
        wr_duty     = sel && wstrb && !addr;
        wr_ctrl     = sel && wstrb && addr;
        presc_d     = tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_wr_d   = wr_duty ? wdata : duty_wr_q;
        duty_act_d  = frame ? duty_wr_q : duty_act_q;
        blink_en_d  = wr_ctrl ? wdata[3:0] : blink_en_q;
        half_d      = wr_ctrl ? wdata[15:8] : half_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (wr_ctrl || half_q == 8'd0) begin
            frame_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end else if (frame) begin
            frame_cnt_d = frame_cnt_q == half_q - 8'd1 ? 8'd0 : frame_cnt_q + 8'd1;
            phase_d     = frame_cnt_q == half_q - 8'd1 ? !phase_q : phase_q;
        end
        // Duty FF is forced fully on so there is no 1/256 dark slot.
        for (int i = 0; i < 4; i++)
            led_d[i] = led_in[i]
                && (duty_act_q[8*i +: 8] == 8'hFF || pwm_cnt_q < duty_act_q[8*i +: 8])
                && (!blink_en_q[i] || phase_q);
        rdata = !sel ? 32'd0 : addr ? {16'd0, half_q, 4'd0, blink_en_q} : duty_wr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= 16'd0;
            pwm_cnt_q   <= 8'd0;
            duty_wr_q   <= 32'hFFFF_FFFF;
            duty_act_q  <= 32'hFFFF_FFFF;
            blink_en_q  <= 4'd0;
            half_q      <= 8'd0;
            frame_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
            led_q       <= 4'd0;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_wr_q   <= duty_wr_d;
            duty_act_q  <= duty_act_d;
            blink_en_q  <= blink_en_d;
            half_q      <= half_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end
endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: directed checks of led_pwm with PRESCALE=1 (main) and PRESCALE=3 (prescaler).
module tb_led_pwm;
    logic        clk = 1'b0;
    logic        reset, sel, rstrb, wstrb, addr;
    logic [31:0] wdata, rdata1, rdata3, v;
    logic [3:0]  led_in, led1, led3;
    int checks = 0, failures = 0;
    int ph, bad, n, off_cnt, on_cnt, c1, c3, o3;
    int c[4];

    always #5 clk = ~clk;

    led_pwm #(.PRESCALE(1)) u_dut (
        .clk(clk), .reset(reset), .sel(sel), .rstrb(rstrb), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .led_in(led_in), .LED(led1)
    );

    led_pwm #(.PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .sel(sel), .rstrb(rstrb), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .led_in(led_in), .LED(led3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ph tracks the pwm count that the current LED sample reflects.
    task automatic adv(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 256;
        end
    endtask

    task automatic go(input int p);
        adv((p - ph + 256) % 256);
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        sel = 1'b1; addr = a; rstrb = 1'b1;
        #1;
        d = rdata1;
        sel = 1'b0; rstrb = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        adv(1);
        sel = 1'b0; wstrb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ph = 0;
        reset = 1'b1; sel = 1'b0; rstrb = 1'b0; wstrb = 1'b0; addr = 1'b0;
        wdata = 32'd0; led_in = 4'b1010;
        adv(2);
        chk("rst_led", led1, 4'b0000);
        rd(1'b0, v); chk("rst_duty", v, 32'hFFFF_FFFF);
        rd(1'b1, v); chk("rst_ctrl", v, 32'd0);
        reset = 1'b0;
        adv(1);
        chk("pass_first", led1, 4'b1010);
        bad = 0;
        repeat (768) begin
            adv(1);
            if (led1 !== 4'b1010) bad++;
        end
        chk("pass_const", bad, 0);
        led_in = 4'b0101;
        #1 chk("pass_lag", led1, 4'b1010);
        adv(1);
        chk("pass_new", led1, 4'b0101);

        wstrb = 1'b1; addr = 1'b0; wdata = 32'd0; rstrb = 1'b1;
        #1 chk("iso_rdata0", rdata1, 32'd0);
        addr = 1'b1;
        #1 chk("iso_rdata1", rdata1, 32'd0);
        adv(1);
        wstrb = 1'b0; rstrb = 1'b0;
        rd(1'b0, v); chk("iso_duty", v, 32'hFFFF_FFFF);
        rd(1'b1, v); chk("iso_ctrl", v, 32'd0);

        led_in = 4'hF;
        sel = 1'b1; wstrb = 1'b1; addr = 1'b0; wdata = 32'h0040_80FF;
        #1 chk("rw_old", rdata1, 32'hFFFF_FFFF);
        adv(1);
        wstrb = 1'b0;
        #1 chk("rw_new", rdata1, 32'h0040_80FF);
        sel = 1'b0;
        bad = 0; n = 0;
        while (led1[3] !== 1'b0 && n < 300) begin
            if (led1 !== 4'hF) bad++;
            adv(1);
            n++;
        end
        chk("shadow_hold", bad, 0);
        chk("shadow_first", led1, 4'b0111);
        ph = 0;
        c = '{0, 0, 0, 0};
        for (int s = 0; s < 256; s++) begin
            for (int i = 0; i < 4; i++) c[i] += int'(led1[i]);
            if (s < 255) adv(1);
        end
        chk("dim_ch0", c[0], 256);
        chk("dim_ch1", c[1], 128);
        chk("dim_ch2", c[2], 64);
        chk("dim_ch3", c[3], 0);

        adv(1);
        go(100);
        wr(1'b0, 32'h1010_1010);
        go(255);
        chk("mid_old", led1, 4'b0001);
        adv(1);
        chk("mid_new", led1, 4'hF);
        go(15);
        chk("duty16_last", led1, 4'hF);
        adv(1);
        chk("duty16_off", led1, 4'h0);

        go(254);
        wr(1'b0, 32'hFF00_FF00);
        adv(1);
        chk("bnd_old0", led1, 4'hF);
        go(20);
        chk("bnd_old20", led1, 4'h0);
        go(0);
        chk("bnd_new0", led1, 4'b1010);
        go(20);
        chk("bnd_new20", led1, 4'b1010);

        wr(1'b0, 32'hFFFF_FFFF);
        go(0);
        wr(1'b1, 32'hFFFF_02F1);
        rd(1'b1, v); chk("ctrl_rd", v, 32'h0000_0201);
        go(255);
        go(0);
        go(255);
        chk("blink_on_end", led1, 4'hF);
        off_cnt = 0; on_cnt = 0; bad = 0;
        for (int s = 0; s < 1024; s++) begin
            adv(1);
            if (s < 512) off_cnt += int'(led1[0]);
            else on_cnt += int'(led1[0]);
            if (led1[3:1] !== 3'b111) bad++;
        end
        chk("blink_off", off_cnt, 0);
        chk("blink_on", on_cnt, 512);
        chk("blink_steady", bad, 0);
        adv(1);
        go(100);
        chk("blink_off100", led1, 4'b1110);

        reset = 1'b1; sel = 1'b1; wstrb = 1'b1; addr = 1'b0; wdata = 32'h1234_5678;
        led_in = 4'b1010;
        adv(1);
        sel = 1'b0; wstrb = 1'b0;
        chk("rst_mid_led", led1, 4'b0000);
        rd(1'b1, v); chk("rst_mid_ctrl", v, 32'd0);
        adv(1);
        reset = 1'b0;
        adv(1);
        chk("rst_resume", led1, 4'b1010);
        rd(1'b0, v); chk("rst_prio", v, 32'hFFFF_FFFF);

        led_in = 4'hF;
        wr(1'b0, 32'h0000_0001);
        adv(800);
        c1 = 0; c3 = 0; o3 = 0;
        repeat (768) begin
            adv(1);
            c1 += int'(led1[0]);
            c3 += int'(led3[0]);
            o3 += int'(|led3[3:1]);
        end
        chk("p1_duty1", c1, 3);
        chk("p3_duty1", c3, 3);
        chk("p3_others", o3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
